// File: rtl/exec_controller_pkg.sv
// ---------------------------------------------------------------------------
// exec_controller_pkg
// Shared definitions for the accumulator-processor execution sequencer:
// sequencer state encoding and default widths for the PC/breakpoint address
// and the retired-instruction counter.
// ---------------------------------------------------------------------------
package exec_controller_pkg;

    // Instruction argument width of the processor; the PC shares it.
    localparam int ARG_WIDTH      = 8;
    localparam int ADDR_WIDTH_DEF = ARG_WIDTH;
    localparam int CNT_WIDTH_DEF  = 16;

    typedef enum logic [1:0] {
        ST_HALT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECODE = 2'd2,
        ST_EXEC   = 2'd3
    } state_e;

endpackage

// File: rtl/exec_controller_bp_unit.sv
// ---------------------------------------------------------------------------
// exec_bp_unit
// PC breakpoint compare with re-arm flag and sticky hit indicator.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   bp_en          breakpoint enable
//   bp_addr, pc    breakpoint address and current PC
//   in_fetch       sequencer is in FETCH
//   resume         sequencer leaves HALT this cycle (run or step)
//   retire         sequencer is in EXEC (instruction retires)
//   bp_fire        combinational: breakpoint matches in this FETCH
//   bp_hit         sticky: last halt was caused by the breakpoint
// ---------------------------------------------------------------------------
module exec_bp_unit
    import exec_controller_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bp_en,
    input  logic [ADDR_WIDTH-1:0] bp_addr,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  in_fetch,
    input  logic                  resume,
    input  logic                  retire,
    output logic                  bp_fire,
    output logic                  bp_hit
);

    logic armed_q, armed_d;
    logic hit_q, hit_d;

    // Disarmed on resume so the instruction at the breakpoint PC executes
    // once; re-armed when any instruction retires.
    assign bp_fire = in_fetch && bp_en && armed_q && (pc == bp_addr);
    assign bp_hit  = hit_q;

    always_comb begin
        armed_d = armed_q;
        hit_d   = hit_q;
        if (resume) begin
            armed_d = 1'b0;
            hit_d   = 1'b0;
        end else if (retire) begin
            armed_d = 1'b1;
        end
        if (bp_fire) hit_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q <= 1'b1;
            hit_q   <= 1'b0;
        end else begin
            armed_q <= armed_d;
            hit_q   <= hit_d;
        end
    end

endmodule

// File: rtl/exec_controller.sv
// ---------------------------------------------------------------------------
// exec_controller
// FETCH/DECODE/EXEC sequencer (3 clocks per instruction) with run/halt/step
// control, PC breakpoint and retired-instruction counter.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   run_req/halt_req/step_req execution control requests
//   bp_en, bp_addr, pc       breakpoint control and current PC
//   id_*_ce                  decoder strobes for the current instruction
//   ir_ce                    load instruction register (FETCH)
//   rf_*_ce, alu_*_ce        gated EXEC enables
//   pc_ce / jmp_ce           PC increment / jump load (EXEC, exclusive)
//   running, halted, bp_hit  status
//   instr_count              retired instructions (wraps)
// ---------------------------------------------------------------------------
module exec_controller
    import exec_controller_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run_req,
    input  logic                  halt_req,
    input  logic                  step_req,
    input  logic                  bp_en,
    input  logic [ADDR_WIDTH-1:0] bp_addr,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  id_ld_ce,
    input  logic                  id_st_ce,
    input  logic                  id_acc_ce,
    input  logic                  id_cy_ce,
    input  logic                  id_jmp_ce,
    output logic                  ir_ce,
    output logic                  rf_ld_ce,
    output logic                  rf_st_ce,
    output logic                  alu_acc_ce,
    output logic                  alu_cy_ce,
    output logic                  pc_ce,
    output logic                  jmp_ce,
    output logic                  running,
    output logic                  halted,
    output logic                  bp_hit,
    output logic [CNT_WIDTH-1:0]  instr_count
);

    state_e               state_q, state_d;
    logic                 run_q, run_d;        // 1 = free-run, 0 = single-step
    logic                 hpend_q, hpend_d;    // halt requested, honoured after EXEC
    logic [4:0]           id_q, id_d;          // {ld, st, acc, cy, jmp}
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 resume;
    logic                 bp_fire;
    logic                 exec_en;

    exec_bp_unit #(.ADDR_WIDTH(ADDR_WIDTH)) u_bp (
        .clk      (clk),
        .rst      (rst),
        .bp_en    (bp_en),
        .bp_addr  (bp_addr),
        .pc       (pc),
        .in_fetch (state_q == ST_FETCH),
        .resume   (resume),
        .retire   (state_q == ST_EXEC),
        .bp_fire  (bp_fire),
        .bp_hit   (bp_hit)
    );

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        hpend_d = hpend_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        resume  = 1'b0;
        case (state_q)
            ST_HALT: begin
                hpend_d = 1'b0;
                if (run_req) begin
                    state_d = ST_FETCH;
                    run_d   = 1'b1;
                    resume  = 1'b1;
                end else if (step_req) begin
                    state_d = ST_FETCH;
                    run_d   = 1'b0;
                    resume  = 1'b1;
                end
            end
            ST_FETCH: begin
                if (halt_req) hpend_d = 1'b1;
                if (bp_fire) begin
                    state_d = ST_HALT;
                    run_d   = 1'b0;
                    hpend_d = 1'b0;
                end else begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (halt_req) hpend_d = 1'b1;
                id_d    = {id_ld_ce, id_st_ce, id_acc_ce, id_cy_ce, id_jmp_ce};
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                cnt_d = cnt_q + 1'b1;
                // A halt_req arriving in EXEC itself still stops at this boundary.
                if (!run_q || hpend_q || halt_req) begin
                    state_d = ST_HALT;
                    run_d   = 1'b0;
                    hpend_d = 1'b0;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_HALT;
            run_q   <= 1'b0;
            hpend_q <= 1'b0;
            id_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            hpend_q <= hpend_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
        end
    end

    // Enables are state decodes; reset masks them so an aborted EXEC never
    // leaks a write in the reset cycle.
    assign exec_en     = (state_q == ST_EXEC) && !rst;
    assign ir_ce       = (state_q == ST_FETCH) && !bp_fire && !rst;
    assign rf_ld_ce    = exec_en && id_q[4];
    assign rf_st_ce    = exec_en && id_q[3];
    assign alu_acc_ce  = exec_en && id_q[2];
    assign alu_cy_ce   = exec_en && id_q[1];
    assign jmp_ce      = exec_en && id_q[0];
    assign pc_ce       = exec_en && !id_q[0];
    assign running     = run_q;
    assign halted      = (state_q == ST_HALT);
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_exec_controller.sv
module tb_exec_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       run_req, halt_req, step_req, bp_en;
    logic [7:0] bp_addr, pc;
    logic       id_ld_ce, id_st_ce, id_acc_ce, id_cy_ce, id_jmp_ce;
    logic       ir_ce, rf_ld_ce, rf_st_ce, alu_acc_ce, alu_cy_ce, pc_ce, jmp_ce;
    logic       running, halted, bp_hit;
    logic [15:0] instr_count;

    // Narrow-counter instance used only for the wrap check.
    logic       s_ir, s_ld, s_st, s_acc, s_cy, s_pc, s_jmp, s_run, s_hlt, s_bph;
    logic [2:0] s_cnt;

    always #5 clk = ~clk;

    exec_controller dut (
        .clk(clk), .rst(rst), .run_req(run_req), .halt_req(halt_req),
        .step_req(step_req), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
        .id_ld_ce(id_ld_ce), .id_st_ce(id_st_ce), .id_acc_ce(id_acc_ce),
        .id_cy_ce(id_cy_ce), .id_jmp_ce(id_jmp_ce), .ir_ce(ir_ce),
        .rf_ld_ce(rf_ld_ce), .rf_st_ce(rf_st_ce), .alu_acc_ce(alu_acc_ce),
        .alu_cy_ce(alu_cy_ce), .pc_ce(pc_ce), .jmp_ce(jmp_ce),
        .running(running), .halted(halted), .bp_hit(bp_hit),
        .instr_count(instr_count)
    );

    exec_controller #(.ADDR_WIDTH(8), .CNT_WIDTH(3)) dut_s (
        .clk(clk), .rst(rst), .run_req(run_req), .halt_req(halt_req),
        .step_req(step_req), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
        .id_ld_ce(id_ld_ce), .id_st_ce(id_st_ce), .id_acc_ce(id_acc_ce),
        .id_cy_ce(id_cy_ce), .id_jmp_ce(id_jmp_ce), .ir_ce(s_ir),
        .rf_ld_ce(s_ld), .rf_st_ce(s_st), .alu_acc_ce(s_acc),
        .alu_cy_ce(s_cy), .pc_ce(s_pc), .jmp_ce(s_jmp),
        .running(s_run), .halted(s_hlt), .bp_hit(s_bph),
        .instr_count(s_cnt)
    );

    typedef struct {
        bit        rq, hq, sq, be;
        bit [7:0]  pc;
        bit [4:0]  id;     // {ld, st, acc, cy, jmp}
        bit        ir;
        bit [5:0]  en;     // {ld, st, acc, cy, pc, jmp}
        bit        run, hlt, bph;
        bit [15:0] cnt;
    } vec_t;

    localparam bit [4:0] ID_ACC = 5'b00100;
    localparam bit [4:0] ID_JMP = 5'b00001;
    localparam bit [5:0] E_ACC  = 6'b001010;
    localparam bit [5:0] E_JMP  = 6'b000001;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t v(bit rq, bit hq, bit sq, bit be, bit [7:0] p,
                               bit [4:0] id, bit ir, bit [5:0] en, bit run,
                               bit hlt, bit bph, int cnt);
        vec_t r;
        r.rq = rq; r.hq = hq; r.sq = sq; r.be = be; r.pc = p; r.id = id;
        r.ir = ir; r.en = en; r.run = run; r.hlt = hlt; r.bph = bph;
        r.cnt = 16'(cnt);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit rq, input bit hq, input bit sq, input bit be,
                         input bit [7:0] p, input bit [4:0] id);
        run_req = rq; halt_req = hq; step_req = sq; bp_en = be; pc = p;
        {id_ld_ce, id_st_ce, id_acc_ce, id_cy_ce, id_jmp_ce} = id;
    endtask

    function automatic logic [5:0] enables();
        return {rf_ld_ce, rf_st_ce, alu_acc_ce, alu_cy_ce, pc_ce, jmp_ce};
    endfunction

    initial begin
        rst = 1'b1;
        bp_addr = 8'h05;
        drive(0, 0, 0, 0, 8'h00, 5'b0);

        // Reset held two cycles, then idle in HALT.
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_status", {29'b0, ir_ce, running, halted}, 32'b001);
            check("idle_en_cnt", {10'b0, enables(), instr_count}, 32'b0);
            tick();
        end

        // Free run, 4 plain ALU ops, then halt_req in DECODE of the 5th.
        tbl.push_back(v(1,0,0,0,0,0,       0,0,0,1,0,0));
        for (int k = 0; k < 4; k++) begin
            tbl.push_back(v(0,0,0,0,8'(k),ID_ACC, 1,0,    1,0,0,k));
            tbl.push_back(v(0,0,0,0,8'(k),ID_ACC, 0,0,    1,0,0,k));
            tbl.push_back(v(0,0,0,0,8'(k),ID_ACC, 0,E_ACC,1,0,0,k));
        end
        tbl.push_back(v(0,0,0,0,4,ID_ACC, 1,0,    1,0,0,4));
        tbl.push_back(v(0,1,0,0,4,ID_ACC, 0,0,    1,0,0,4));
        tbl.push_back(v(0,0,0,0,4,ID_ACC, 0,E_ACC,1,0,0,4));
        tbl.push_back(v(0,0,0,0,5,0,      0,0,    0,1,0,5));
        tbl.push_back(v(0,0,0,0,5,0,      0,0,    0,1,0,5));
        // Single step of a jump; a halt_req seen in HALT is dropped.
        tbl.push_back(v(0,0,1,0,5,ID_JMP, 0,0,    0,1,0,5));
        tbl.push_back(v(0,0,0,0,5,ID_JMP, 1,0,    0,0,0,5));
        tbl.push_back(v(0,0,0,0,5,ID_JMP, 0,0,    0,0,0,5));
        tbl.push_back(v(0,0,0,0,5,ID_JMP, 0,E_JMP,0,0,0,5));
        tbl.push_back(v(0,0,0,0,9,0,      0,0,    0,1,0,6));
        tbl.push_back(v(0,1,0,0,9,0,      0,0,    0,1,0,6));
        // Breakpoint at 5: hit in FETCH, resume executes PC 5 once.
        tbl.push_back(v(1,0,0,1,3,0,      0,0,    0,1,0,6));
        tbl.push_back(v(0,0,0,1,3,ID_ACC, 1,0,    1,0,0,6));
        tbl.push_back(v(0,0,0,1,3,ID_ACC, 0,0,    1,0,0,6));
        tbl.push_back(v(0,0,0,1,3,ID_ACC, 0,E_ACC,1,0,0,6));
        tbl.push_back(v(0,0,0,1,4,ID_ACC, 1,0,    1,0,0,7));
        tbl.push_back(v(0,0,0,1,4,ID_ACC, 0,0,    1,0,0,7));
        tbl.push_back(v(0,0,0,1,4,ID_ACC, 0,E_ACC,1,0,0,7));
        tbl.push_back(v(0,0,0,1,5,ID_ACC, 0,0,    1,0,0,8));
        tbl.push_back(v(0,0,0,1,5,0,      0,0,    0,1,1,8));
        tbl.push_back(v(1,0,0,1,5,0,      0,0,    0,1,1,8));
        tbl.push_back(v(0,0,0,1,5,ID_ACC, 1,0,    1,0,0,8));
        tbl.push_back(v(0,0,0,1,5,ID_ACC, 0,0,    1,0,0,8));
        tbl.push_back(v(0,0,0,1,5,ID_ACC, 0,E_ACC,1,0,0,8));
        tbl.push_back(v(0,0,0,1,6,ID_ACC, 1,0,    1,0,0,9));
        tbl.push_back(v(0,1,0,1,6,ID_ACC, 0,0,    1,0,0,9));
        tbl.push_back(v(0,0,0,1,6,ID_ACC, 0,E_ACC,1,0,0,9));
        tbl.push_back(v(0,0,0,1,6,0,      0,0,    0,1,0,10));

        foreach (tbl[i]) begin
            drive(tbl[i].rq, tbl[i].hq, tbl[i].sq, tbl[i].be, tbl[i].pc, tbl[i].id);
            @(negedge clk);
            check($sformatf("vec%0d_ctl", i),
                  {26'b0, ir_ce, running, halted, bp_hit, 2'b0},
                  {26'b0, tbl[i].ir, tbl[i].run, tbl[i].hlt, tbl[i].bph, 2'b0});
            check($sformatf("vec%0d_en_cnt", i), {10'b0, enables(), instr_count},
                  {10'b0, tbl[i].en, tbl[i].cnt});
            tick();
        end

        // Reset during EXEC aborts the instruction.
        drive(1, 0, 0, 0, 8'h10, ID_ACC); tick();   // HALT -> FETCH
        drive(0, 0, 0, 0, 8'h10, ID_ACC); tick();   // FETCH -> DECODE
        tick();                                      // DECODE -> EXEC
        rst = 1'b1;
        @(negedge clk);
        check("rst_cycle_en", {26'b0, enables()}, 32'b0);
        check("rst_cycle_ir", {31'b0, ir_ce}, 32'b0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_status", {28'b0, ir_ce, running, halted, bp_hit}, 32'b0010);
        check("post_rst_en_cnt", {10'b0, enables(), instr_count}, 32'b0);
        check("post_rst_small_cnt", {29'b0, s_cnt}, 32'b0);

        // Counter wrap on the 3-bit instance: 7 -> 0 -> 1.
        drive(1, 0, 0, 0, 8'h20, ID_ACC); tick();
        drive(0, 0, 0, 0, 8'h20, ID_ACC);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("wrap_fetch%0d", k), {31'b0, ir_ce}, 32'b1);
            check($sformatf("wrap_cnt16_%0d", k), {16'b0, instr_count}, 32'(k));
            check($sformatf("wrap_cnt3_%0d", k), {29'b0, s_cnt}, 32'(k % 8));
            tick(); tick(); tick();
        end
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        tick(); tick();
        @(negedge clk);
        check("final_halted", {31'b0, halted}, 32'b1);
        check("final_cnt3", {29'b0, s_cnt}, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exec_controller.md
Name: exec_controller

Overview:
Multi-cycle sequencer for the 8-bit accumulator processor. It drives the PC, instruction register, register file and ALU through a FETCH/DECODE/EXEC cycle, one instruction every 3 clocks. It adds run/halt/single-step control, a PC breakpoint and a retired-instruction counter. It sits between the instruction decoder's strobe outputs and the clock-enable inputs of PC, RF and ALU.

Parameters:
ADDR_WIDTH, 8, width of program counter and breakpoint address
CNT_WIDTH, 16, width of retired-instruction counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
run_req  in  1  level/pulse; start free-running execution
halt_req  in  1  pulse; stop at the next instruction boundary
step_req  in  1  pulse; execute exactly one instruction while halted
bp_en  in  1  breakpoint enable
bp_addr  in  ADDR_WIDTH  breakpoint PC value
pc  in  ADDR_WIDTH  current program counter
id_ld_ce, id_st_ce, id_acc_ce, id_cy_ce, id_jmp_ce  in  1 each  decoder/ALU strobes for the current instruction
ir_ce  out  1  latch ROM output into instruction register
rf_ld_ce, rf_st_ce, alu_acc_ce, alu_cy_ce  out  1 each  gated enables, one EXEC cycle
pc_ce  out  1  PC increment enable
jmp_ce  out  1  PC load-from-jump enable
running  out  1  1 when in free-run mode
halted  out  1  1 in HALT state
bp_hit  out  1  sticky; set when halted by breakpoint
instr_count  out  CNT_WIDTH  retired instructions

Behaviour:
- States: HALT, FETCH, DECODE, EXEC. Mode flag is RUN or STEP.
- Reset puts the block in HALT with mode RUN cleared. Every output is 0 except halted=1. instr_count=0. bp_hit=0. bp_armed=1.
- Synchronous reset has priority over everything and aborts an instruction mid-flight. No enable is asserted in the reset cycle.
- HALT:
  - halted=1.
  - run_req: go to FETCH, running=1, bp_hit cleared, bp_armed cleared.
  - else step_req: go to FETCH in STEP mode, bp_hit cleared, bp_armed cleared.
  - If run_req and step_req arrive together, run wins.
- FETCH:
  - Breakpoint check first: if bp_en && bp_armed && pc==bp_addr, go to HALT and set bp_hit=1, running=0. ir_ce is not asserted.
  - Otherwise ir_ce=1 for this cycle, then go to DECODE.
- DECODE: no enables asserted. Capture the id_* strobes into internal registers at the end of the cycle. Go to EXEC.
- EXEC: exactly one cycle.
  - Drive the registered ld/st/acc/cy strobes onto rf_ld_ce, rf_st_ce, alu_acc_ce, alu_cy_ce.
  - jmp_ce equals the registered id_jmp_ce; pc_ce is its complement. Exactly one of the two is high.
  - instr_count increments, wrapping modulo 2^CNT_WIDTH.
  - bp_armed is set to 1.
  - Next state is HALT if in STEP mode or a halt is pending; otherwise FETCH.
- halt_req is latched into a pending flag in any non-HALT state. The flag is honored only at the end of EXEC and cleared on entry to HALT. A halt_req seen while in HALT is ignored.
- Re-arming rule: resuming or stepping from a breakpointed PC executes that instruction once. The breakpoint fires again only on a later arrival at bp_addr.
- Latency:
  - 3 clocks per instruction.
  - run_req in HALT leads to ir_ce 1 clock later.
  - First pc_ce/jmp_ce occurs 3 clocks after leaving HALT.
- Output enables are Moore outputs: registered state decode, no combinational path from request inputs.

Decomposition:
- A shared package holds:
  - state encoding constants (HALT=2'd0, FETCH=2'd1, DECODE=2'd2, EXEC=2'd3);
  - ADDR_WIDTH default tied to the existing argument-width constant;
  - CNT_WIDTH default.
- One sub-module is natural: exec_bp_unit. It holds the breakpoint compare, the bp_armed flag and sticky bp_hit.

Test Plan:
1. Reset held 2 cycles, then released with no requests -> halted=1, all enables 0, instr_count=0 for 10 cycles.
2. run_req pulse, decoder reports plain ALU op (id_acc_ce=1, id_jmp_ce=0) -> per 3-cycle period: ir_ce at cycle 1, alu_acc_ce=1 and pc_ce=1 at cycle 3. After 4 instructions instr_count=4.
3. Halted, step_req with id_jmp_ce=1 -> one ir_ce, then jmp_ce=1 and pc_ce=0 in EXEC, then back to HALT. instr_count +1.
4. bp_en=1, bp_addr=8'h05, running with pc reaching 5 -> HALT at FETCH with no ir_ce and bp_hit=1. A later run_req executes PC 5 without re-hitting, and bp_hit clears.
5. halt_req during DECODE -> current instruction completes its EXEC, then HALT. No further ir_ce.
6. rst asserted during EXEC -> next cycle halted=1, all enables 0, instr_count=0. Set instr_count near 16'hFFFF and run 2 instructions -> count wraps to 16'h0000 then 16'h0001.
